// File: rtl/mc6809e_bus_responder.sv
// MC6809E E/Q clock-enable generator and memory-mapped byte register target with optional E stretch.
// DIn/DRIVE one-clock registered; writes commit at E fall; define MC6809E_RESP_IRQ_EN for the top-offset IRQ doorbell.
module mc6809e_bus_responder #(
  parameter int          CLK_DIV     = 4,
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter int          ADDR_BITS   = 4,
  parameter int          WAIT_STATES = 0
) (
  input  logic        CLK_ROOT,
  input  logic        RESET,
  output logic        E,
  output logic        Q,
  output logic        CE_Q_FALL,
  output logic        CE_E_FALL,
  input  logic [15:0] ADDR,
  input  logic        RnW,
  input  logic        BA,
  input  logic [7:0]  DOut,
  output logic [7:0]  DIn,
  output logic        DRIVE,
  output logic        HIT,
  output logic        nIRQ
);

  localparam int DEPTH    = 1 << ADDR_BITS;
  localparam int DW       = $clog2(CLK_DIV);
  localparam int WAIT_MAX = WAIT_STATES * CLK_DIV;
  localparam int WW       = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(WAIT_MAX);

  typedef enum logic [1:0] {PH_0, PH_1, PH_2, PH_3} phase_t;

  phase_t              r_phase;
  logic [DW-1:0]       r_div;
  logic [WW-1:0]       r_wait;
  logic [7:0]          r_din;
  logic                r_drive;
  logic [7:0]          r_regs [DEPTH];

  phase_t              w_phase_nxt;
  logic [DW-1:0]       w_div_nxt;
  logic [WW-1:0]       w_wait_nxt;
  logic                w_stall;
  logic                w_hit;
  logic                w_ce_e;
  logic                w_wr;
  logic [ADDR_BITS-1:0] w_off;

  assign w_hit   = !BA && (ADDR[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);
  assign w_off   = ADDR[ADDR_BITS-1:0];
  assign w_stall = (r_phase == PH_3) && (r_wait != '0);
  assign w_ce_e  = (r_phase == PH_3) && (r_div == DIV_LAST) && (r_wait == '0);
  assign w_wr    = w_ce_e && w_hit && !RnW;

  assign E         = r_phase[1];
  assign Q         = (r_phase == PH_1) || (r_phase == PH_2);
  assign CE_Q_FALL = (r_phase == PH_2) && (r_div == DIV_LAST);
  assign CE_E_FALL = w_ce_e;
  assign HIT       = w_hit;
  assign DIn       = r_din;
  assign DRIVE     = r_drive;

  always_ff @(posedge CLK_ROOT) begin
    if (RESET) begin
      r_phase <= PH_0;
      r_div   <= '0;
      r_wait  <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      r_div   <= w_div_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  // div parks on its last count while the stretch counter drains in phase 3
  always_comb begin
    w_phase_nxt = r_phase;
    w_div_nxt   = r_div;
    w_wait_nxt  = r_wait;
    if (r_div != DIV_LAST) begin
      w_div_nxt = r_div + 1'b1;
    end else if (w_stall) begin
      w_wait_nxt = r_wait - 1'b1;
    end else begin
      w_div_nxt = '0;
      case (r_phase)
        PH_0:    w_phase_nxt = PH_1;
        PH_1:    w_phase_nxt = PH_2;
        PH_2: begin
          w_phase_nxt = PH_3;
          w_wait_nxt  = w_hit ? WAIT_LOAD : '0;
        end
        default: w_phase_nxt = PH_0;
      endcase
    end
  end

  always_ff @(posedge CLK_ROOT) begin
    if (RESET) begin
      r_din   <= 8'hFF;
      r_drive <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= 8'h00;
    end else begin
      r_din   <= (w_hit && RnW) ? r_regs[w_off] : 8'hFF;
      r_drive <= w_hit && RnW && w_phase_nxt[1];
      if (w_wr) r_regs[w_off] <= DOut;
    end
  end

`ifdef MC6809E_RESP_IRQ_EN
  localparam logic [ADDR_BITS-1:0] TOP_OFF = '1;
  logic r_nirq;

  // doorbell: write to top offset raises the request, a read of it acknowledges
  always_ff @(posedge CLK_ROOT) begin
    if (RESET) begin
      r_nirq <= 1'b1;
    end else if (w_ce_e && w_hit && (w_off == TOP_OFF)) begin
      r_nirq <= RnW;
    end
  end

  assign nIRQ = r_nirq;
`else
  assign nIRQ = 1'b1;
`endif

endmodule

// File: tb/tb_mc6809e_bus_responder.sv
// Randomized bus-cycle bench for mc6809e_bus_responder against a per-cycle timing and register-file model.
module tb_mc6809e_bus_responder;

  localparam int WS = 2;
  localparam int CD = 4;

  logic        CLK_ROOT = 1'b0;
  logic        RESET    = 1'b1;
  logic        E, Q, CE_Q_FALL, CE_E_FALL;
  logic [15:0] ADDR = 16'h0000;
  logic        RnW  = 1'b1;
  logic        BA   = 1'b1;
  logic [7:0]  DOut = 8'h00;
  logic [7:0]  DIn;
  logic        DRIVE, HIT, nIRQ;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  m_mem [16];
  logic        m_nirq;

  mc6809e_bus_responder #(
    .CLK_DIV(CD), .BASE_ADDR(16'hFF00), .ADDR_BITS(4), .WAIT_STATES(WS)
  ) dut (
    .CLK_ROOT(CLK_ROOT), .RESET(RESET), .E(E), .Q(Q),
    .CE_Q_FALL(CE_Q_FALL), .CE_E_FALL(CE_E_FALL),
    .ADDR(ADDR), .RnW(RnW), .BA(BA), .DOut(DOut),
    .DIn(DIn), .DRIVE(DRIVE), .HIT(HIT), .nIRQ(nIRQ)
  );

  always #5 CLK_ROOT = ~CLK_ROOT;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic in_window(input logic [15:0] a, input logic ba);
    return !ba && (a[15:4] == 12'hFF0);
  endfunction

  task automatic check_reset_outs();
    check_val("rst_E", 16'(E), 16'd0);
    check_val("rst_Q", 16'(Q), 16'd0);
    check_val("rst_CEQ", 16'(CE_Q_FALL), 16'd0);
    check_val("rst_CEE", 16'(CE_E_FALL), 16'd0);
    check_val("rst_DIn", 16'(DIn), 16'h00FF);
    check_val("rst_DRIVE", 16'(DRIVE), 16'd0);
    check_val("rst_nIRQ", 16'(nIRQ), 16'd1);
  endtask

  // Leaves the caller just after a rising edge, in the first clock of phase 0.
  task automatic do_reset(input int n);
    RESET = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK_ROOT); #1;
      @(negedge CLK_ROOT);
      check_reset_outs();
    end
    @(posedge CLK_ROOT); #1;
    RESET = 1'b0;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_nirq = 1'b1;
  endtask

  // One full E cycle with the bus held constant; rst_at >= 0 aborts it with a reset at that clock.
  task automatic bus_cycle(input logic [15:0] a, input logic rd, input logic ba,
                           input logic [7:0] d, input int rst_at);
    logic       hit;
    int         len;
    logic [7:0] exp_din;
    ADDR = a; RnW = rd; BA = ba; DOut = d;
    hit     = in_window(a, ba);
    len     = hit ? 16 + WS * CD : 16;
    exp_din = (hit && rd) ? m_mem[a[3:0]] : 8'hFF;
    for (int k = 0; k < len; k++) begin
      @(negedge CLK_ROOT);
      check_val("E", 16'(E), 16'(k >= 8));
      check_val("Q", 16'(Q), 16'(k >= 4 && k < 12));
      check_val("CE_Q_FALL", 16'(CE_Q_FALL), 16'(k == 11));
      check_val("CE_E_FALL", 16'(CE_E_FALL), 16'(k == len - 1));
      check_val("HIT", 16'(HIT), 16'(hit));
      check_val("nIRQ", 16'(nIRQ), 16'(m_nirq));
      check_val("DRIVE", 16'(DRIVE), 16'(hit && rd && k >= 8));
      if (k >= 1) check_val("DIn", 16'(DIn), 16'(exp_din));
      if (k == rst_at) begin
        do_reset(2);
        return;
      end
      @(posedge CLK_ROOT); #1;
    end
    if (hit && !rd) m_mem[a[3:0]] = d;
`ifdef MC6809E_RESP_IRQ_EN
    if (hit && a[3:0] == 4'hF) m_nirq = rd;
`endif
  endtask

  initial begin
    logic [15:0] a;
    logic        rd, ba;
    logic [7:0]  d;
    int          ra;

    do_reset(3);

    // free-running timing with no target access
    bus_cycle(16'hFF02, 1'b1, 1'b1, 8'h00, -1);
    bus_cycle(16'h1234, 1'b1, 1'b0, 8'h00, -1);

    // write then read back; neighbouring window misses
    bus_cycle(16'hFF03, 1'b0, 1'b0, 8'hA5, -1);
    bus_cycle(16'hFF03, 1'b1, 1'b0, 8'h00, -1);
    bus_cycle(16'hFF13, 1'b1, 1'b0, 8'h00, -1);

    // stretched hit followed by unstretched miss
    bus_cycle(16'hFF00, 1'b1, 1'b0, 8'h00, -1);
    bus_cycle(16'h1234, 1'b0, 1'b0, 8'h77, -1);

    // BA=1 suppresses the write
    bus_cycle(16'hFF02, 1'b0, 1'b1, 8'h3C, -1);
    bus_cycle(16'hFF02, 1'b1, 1'b0, 8'h00, -1);

    // reset in the middle of the stretch drops the pending write
    bus_cycle(16'hFF01, 1'b0, 1'b0, 8'h5A, 18);
    bus_cycle(16'hFF01, 1'b1, 1'b0, 8'h00, -1);
    bus_cycle(16'hFF03, 1'b1, 1'b0, 8'h00, -1);

    // doorbell offset: write, idle read, acknowledge read, idle read
    bus_cycle(16'hFF0F, 1'b0, 1'b0, 8'h01, -1);
    bus_cycle(16'hFF00, 1'b1, 1'b0, 8'h00, -1);
    bus_cycle(16'hFF0F, 1'b1, 1'b0, 8'h00, -1);
    bus_cycle(16'hFF00, 1'b1, 1'b0, 8'h00, -1);

    for (int n = 0; n < 160; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = {12'hFF0, 4'($urandom_range(0, 15))};
        2:       a = 16'hFF0F;
        default: a = 16'($urandom);
      endcase
      ba = ($urandom_range(0, 4) == 0);
      rd = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      ra = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 15)) : -1;
      bus_cycle(a, rd, ba, d, ra);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
